// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) even-parity definitions.
// Codeword layout is {d3,d2,d1,p2,d0,p1,p0}.
package hamming_pkg;

    localparam int HAM_DATA_W = 4;
    localparam int HAM_CODE_W = 7;

    localparam int B_P0 = 0;
    localparam int B_P1 = 1;
    localparam int B_D0 = 2;
    localparam int B_P2 = 3;
    localparam int B_D1 = 4;
    localparam int B_D2 = 5;
    localparam int B_D3 = 6;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    function automatic logic [HAM_CODE_W-1:0] ham74_encode(
        input logic [HAM_DATA_W-1:0] d
    );
        logic [HAM_CODE_W-1:0] c;
        c       = '0;
        c[B_D0] = d[0];
        c[B_D1] = d[1];
        c[B_D2] = d[2];
        c[B_D3] = d[3];
        c[B_P0] = d[0] ^ d[1] ^ d[3];
        c[B_P1] = d[0] ^ d[2] ^ d[3];
        c[B_P2] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_encoder_74.sv
// Combinational Hamming(7,4) even-parity encoder.
// Shared across the codebase; wraps ham74_encode.
module hamming_encoder_74
    import hamming_pkg::*;
(
    input  logic [HAM_DATA_W-1:0] data,
    output logic [HAM_CODE_W-1:0] code
);

    assign code = ham74_encode(data);

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbitration of NUM_REQ nibble sources onto one
// Hamming(7,4) encoder with a one-entry valid/ready output stage.
module hamming_enc_arbiter
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [4*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HAM_CODE_W-1:0]   out_code,
    output logic [ID_W-1:0]         out_id,
    output logic [CNT_W-1:0]        code_count
);

    localparam logic [ID_W:0]   NREQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    ostate_t                 state;
    logic                    live;
    logic [ID_W-1:0]         rr_ptr;

    logic [2*NUM_REQ-1:0]    dbl;
    logic [2*NUM_REQ-1:0]    shifted;
    logic [NUM_REQ-1:0]      rot;
    logic [ID_W-1:0]         off;
    logic [ID_W:0]           sum;
    logic                    any;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         next_ptr;
    logic                    can_accept;
    logic                    xfer;
    logic [HAM_DATA_W-1:0]   nibble;
    logic [HAM_CODE_W-1:0]   enc;

    // Rotate so rr_ptr sits at bit 0, pick lowest, rotate back.
    always_comb begin
        dbl     = {req_valid, req_valid};
        shifted = dbl >> rr_ptr;
        rot     = shifted[NUM_REQ-1:0];
        any     = 1'b0;
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = ID_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        grant_id = sum[ID_W-1:0];
    end

    assign next_ptr   = (grant_id == LAST) ? '0 : grant_id + ID_W'(1);
    assign out_valid  = (state == FULL);
    // live blocks grants until the first edge after reset release
    assign can_accept = live & (!out_valid | out_ready);
    assign xfer       = any & can_accept;
    assign req_ready  = xfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign nibble     = req_data[{grant_id, 2'b00} +: HAM_DATA_W];

    hamming_encoder_74 u_enc (
        .data (nibble),
        .code (enc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            live       <= 1'b0;
            rr_ptr     <= '0;
            out_code   <= '0;
            out_id     <= '0;
            code_count <= '0;
        end else begin
            live <= 1'b1;
            if (out_valid && out_ready && (code_count != '1)) begin
                code_count <= code_count + CNT_W'(1);
            end
            unique case (state)
                EMPTY: begin
                    if (xfer) begin
                        state    <= FULL;
                        out_code <= enc;
                        out_id   <= grant_id;
                        rr_ptr   <= next_ptr;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        out_code <= enc;
                        out_id   <= grant_id;
                        rr_ptr   <= next_ptr;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed bench for hamming_enc_arbiter; a second instance with
// a 4-bit counter covers saturation.
module tb_hamming_enc_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_code;
    logic [1:0]  out_id;
    logic [15:0] code_count;

    logic        rst2_n;
    logic [3:0]  req_ready2;
    logic        out_valid2;
    logic [6:0]  out_code2;
    logic [1:0]  out_id2;
    logic [3:0]  code_count2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hamming_enc_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_id     (out_id),
        .code_count (code_count)
    );

    hamming_enc_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst2_n),
        .req_valid  (4'b0001),
        .req_data   (16'h000B),
        .req_ready  (req_ready2),
        .out_valid  (out_valid2),
        .out_ready  (1'b1),
        .out_code   (out_code2),
        .out_id     (out_id2),
        .code_count (code_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         ids [5];
        logic [6:0] ctab [4];
        ids  = '{1, 2, 3, 0, 1};
        ctab = '{7'h00, 7'h07, 7'h7F, 7'h55};

        rst_n     = 1'b0;
        rst2_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_code", 32'(out_code), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_cnt", 32'(code_count), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        step();

        // single request, nibble B
        req_valid = 4'b0001;
        req_data  = 16'h000B;
        out_ready = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_code", 32'(out_code), 32'h55);
        chk("t1_id", 32'(out_id), 0);
        step();
        chk("t1_cnt", 32'(code_count), 1);
        chk("t1_drain", 32'(out_valid), 0);

        // all valid; pointer now at 1
        req_data  = 16'hBF10;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << ids[k]));
            step();
            chk("rr_id", 32'(out_id), 32'(ids[k]));
            chk("rr_code", 32'(out_code), 32'(ctab[ids[k]]));
        end
        chk("rr_cnt", 32'(code_count), 5);

        // hold with out_ready low
        out_ready = 1'b0;
        #1;
        chk("hold_ready0", 32'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_id", 32'(out_id), 1);
            chk("hold_code", 32'(out_code), 32'h07);
            chk("hold_ready", 32'(req_ready), 0);
        end
        chk("hold_cnt", 32'(code_count), 5);
        out_ready = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'h4);
        step();
        chk("rel_id", 32'(out_id), 2);
        chk("rel_code", 32'(out_code), 32'h7F);
        chk("rel_cnt", 32'(code_count), 6);
        req_valid = '0;
        step();
        chk("rel_empty", 32'(out_valid), 0);

        // pointer is 3: only req 2, then only req 1 (wrap)
        req_valid = 4'b0100;
        #1;
        chk("wrap_r2", 32'(req_ready), 32'h4);
        step();
        chk("wrap_id2", 32'(out_id), 2);
        req_valid = 4'b0010;
        #1;
        chk("wrap_r1", 32'(req_ready), 32'h2);
        step();
        chk("wrap_id1", 32'(out_id), 1);
        chk("wrap_code1", 32'(out_code), 32'h07);
        req_valid = '0;
        step();
        chk("wrap_cnt", 32'(code_count), 9);

        // reset mid-burst
        req_valid = 4'b1111;
        step();
        step();
        chk("mid_full", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_code", 32'(out_code), 0);
        chk("mid_id", 32'(out_id), 0);
        chk("mid_cnt", 32'(code_count), 0);
        chk("mid_ready", 32'(req_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rel_ready", 32'(req_ready), 0);
        step();
        chk("post_valid", 32'(out_valid), 0);
        chk("post_ready", 32'(req_ready), 32'h1);
        step();
        chk("post_id", 32'(out_id), 0);
        chk("post_code", 32'(out_code), 32'h00);
        req_valid = '0;

        // saturation on the 4-bit counter instance
        rst2_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("sat_mid", 32'(code_count2), 8);
        for (int k = 0; k < 12; k++) step();
        chk("sat_top", 32'(code_count2), 32'hF);
        for (int k = 0; k < 8; k++) step();
        chk("sat_hold", 32'(code_count2), 32'hF);
        chk("sat_code", 32'(out_code2), 32'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hamming_enc_arbiter.md
# hamming_enc_arbiter

Shares a single Hamming(7,4) even-parity encoder between `NUM_REQ` requesters. Each requester offers a 4-bit nibble over a valid/ready handshake. A round-robin arbiter grants one requester per cycle and encodes its nibble. The 7-bit codeword is registered together with the winner's ID into a one-entry output stage with its own valid/ready handshake. The block sits between the packet sources and the downstream error-detection path, and is the only place codewords are produced.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the ID field. Derived; do not override.
- `CNT_W`, default 16: width of the codeword counter.

Ports:
- `clk`  in  1  rising-edge clock, single domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  4*NUM_REQ  nibble of requester i at bits [4i+3:4i].
- `req_ready`  out  NUM_REQ  one-hot-or-zero accept strobe.
- `out_valid`  out  1  codeword held in the output stage.
- `out_ready`  in  1  downstream accepts.
- `out_code`  out  7  codeword {d3,d2,d1,p2,d0,p1,p0}.
- `out_id`  out  ID_W  index of the requester that produced `out_code`.
- `code_count`  out  CNT_W  saturating count of codewords delivered downstream.

## Operation
**Parity (even):**
- p0 = d0^d1^d3
- p1 = d0^d2^d3
- p2 = d1^d2^d3

**Output stage states:**
- EMPTY: `out_valid`=0.
- FULL: `out_valid`=1.

**Accept condition:**
- `can_accept` = EMPTY, or (FULL and `out_ready`).

**Arbitration:**
- Round-robin pointer `rr_ptr`.
- The grant goes to the first i with `req_valid[i]`=1, searching from `rr_ptr` upward with wrap.
- `req_ready[i]` = grant[i] & `can_accept`. It is combinational from `req_valid`, `rr_ptr`, state and `out_ready`.

**Transfer:**
- A request transfers when `req_valid[i]` & `req_ready[i]`.
- On transfer, the encoded nibble and i are loaded into `out_code`/`out_id`, and the state becomes or stays FULL.
- On transfer, `rr_ptr` ← (i+1) mod NUM_REQ. It is unchanged when there is no transfer.

**Drain:**
- FULL & `out_ready` with no transfer → EMPTY.
- FULL & `out_ready` with a transfer → stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle.

**Hold:**
- While FULL & !`out_ready`: `out_code`/`out_id` are stable and all `req_ready`=0.

**Counter:**
- `code_count` increments on each `out_valid` & `out_ready`.
- It saturates at all-ones and does not wrap.

**Misuse:**
- A requester dropping `req_valid` without a transfer is permitted; that request is simply not granted.
- `req_data` is sampled only on its transfer cycle.

## Timing
- Reset values: `out_valid`=0, `out_code`=0, `out_id`=0, `code_count`=0, `rr_ptr`=0, state EMPTY, `req_ready`=0.
- Latency: a transfer in cycle N gives `out_valid`=1 with the codeword in cycle N+1.
- Throughput: 1 codeword/cycle while `out_ready`=1.
- Simultaneous drain and accept in the same cycle: both occur. The counter increments and the new word is loaded.
- Reset asserted mid-operation: the held word is discarded, all state returns to reset values immediately, and no `req_ready` is asserted until after the first clock edge following deassertion.
- Pointer wrap: after granting NUM_REQ-1, the pointer returns to 0.
- No requests, or `can_accept`=0: the pointer holds.

## Structure
- Shared package `hamming_pkg`:
  - `HAM_DATA_W`=4, `HAM_CODE_W`=7.
  - Bit-position constants for p0/p1/d0/p2/d1/d2/d3 (0..6).
  - Function `ham74_encode`.
- Sub-module `hamming_encoder_74`: purely combinational, 4→7. It is instantiated once in this block and reused by the rest of the codebase.
- The round-robin arbiter stays inline: a rotate, priority-encode and rotate-back on `rr_ptr`.

## Test plan
- Reset, then requester 0 offers 4'b1011 with `out_ready`=1 → `req_ready[0]`=1 in cycle 0. Next cycle `out_valid`=1, `out_code`=7'h55, `out_id`=0. `code_count`=1 after the drain.
- All four requesters valid continuously with nibbles 0, 1, F, B and `out_ready`=1 → grant order 0,1,2,3,0…, one per cycle. Codes 7'h00, 7'h07, 7'h7F, 7'h55.
- Output held FULL with `out_ready`=0 for 5 cycles while requests are pending → `req_ready`=0 and `out_code`/`out_id` stable. On `out_ready`=1, drain and accept occur in the same cycle.
- Only requester 2 valid, then only requester 1 → grant 2, pointer moves to 3, requester 1 is still granted next via wrap. Verify `out_id` = 2 then 1.
- Assert `rst_n` low while FULL mid-burst → `out_valid` drops asynchronously and all outputs return to reset values. After release, arbitration restarts from requester 0.
- Force `code_count` near all-ones with CNT_W=4 and run 20 transfers → the count stops at 4'hF.
